gt_reset_sequencer: RTL
=======================

// Module: gt_reset_sequencer
// PURPOSE
// - Init-clock-domain reset sequencer; consumer of the transceiver clock buffer's CLR input and usrclk_active output.
// - Sequences GT PLL reset, BUFG_GT clear release and user datapath reset.
// - Waits for PLL lock and usrclk_active with timeouts, retrying up to a limit.
// - Re-runs the full sequence if lock or clock activity is lost.
// PARAMETERS
// - CLR_CYCLES      16     cycles gt_pll_rst/bufg_clr held asserted in RESET_PLL (>=2)
// - LOCK_TIMEOUT    65536  max cycles in WAIT_LOCK before retry
// - ACTIVE_TIMEOUT  1024   max cycles in WAIT_ACTIVE before retry
// - DP_RST_CYCLES   32     cycles datapath_rst held after usrclk_active seen (>=1)
// - MAX_RETRIES     3      timeouts tolerated before FAILED (1..15)
// PORTS
// - clk                  in   1  free-running init clock; all logic on posedge
// - rst_n                in   1  asynchronous, active-low reset
// - start                in   1  sync pulse: restart sequence from RESET_PLL, clear retries/error
// - pll_lock_async       in   1  GT PLL lock, asynchronous; 2-flop synchronized
// - usrclk_active_async  in   1  clock-buffer usrclk_active, asynchronous; 2-flop synchronized
// - gt_pll_rst           out  1  GT PLL reset, active-high
// - bufg_clr             out  1  drives clock-buffer rst (BUFG_GT CLR), active-high
// - datapath_rst         out  1  user datapath reset, active-high
// - reset_done           out  1  sequence complete, clocks stable
// - seq_error            out  1  MAX_RETRIES exhausted; sticky until start or rst_n
// - retry_count          out  4  timeouts in current sequence
// BEHAVIOUR
// - All outputs registered.
// - rst_n low values: gt_pll_rst=1, bufg_clr=1, datapath_rst=1, reset_done=0, seq_error=0, retry_count=0.
// - FSM state RESET_PLL, cycle counter 0.
// - Synchronizers: lock_s/active_s lag async inputs by 2 clk.
// - One shared cycle counter, width $clog2(max param)+1; cleared on every state change.
// - States:
//   RESET_PLL: pll_rst=1, clr=1, dp_rst=1, done=0. Stay CLR_CYCLES cycles -> WAIT_LOCK.
//   WAIT_LOCK: pll_rst=0, clr=1. lock_s=1 -> WAIT_ACTIVE. Count reaches LOCK_TIMEOUT-1 -> RETRY.
//   WAIT_ACTIVE: clr=0. active_s=1 -> DP_RESET. lock_s=0 -> RETRY. Count reaches ACTIVE_TIMEOUT-1 -> RETRY.
//   DP_RESET: clr=0, dp_rst=1. DP_RST_CYCLES cycles -> DONE. lock_s or active_s falls -> RESET_PLL; counts as retry.
//   DONE: dp_rst=0, done=1. lock_s=0 or active_s=0 -> RESET_PLL; retry_count cleared; link-loss restart, not a retry.
//   RETRY (1 cycle): retry_count+1. New value == MAX_RETRIES -> FAILED, else -> RESET_PLL.
//   FAILED: pll_rst=1, clr=1, dp_rst=1, done=0, seq_error=1. Leave only via start.
// - Output update timing:
//   - Outputs take new-state values the cycle after the transition is decided (1 clk).
//   - Async input edge to output change = 3 clk.
// - start:
//   - In any state, start -> RESET_PLL next cycle; retry_count=0, seq_error=0.
//   - start has priority over every other transition.
// - Same-cycle events:
//   - Timeout and lock/active arriving in the same cycle: success wins.
//   - lock loss and active arriving in WAIT_ACTIVE: lock loss wins.
// - retry_count saturates at 15.
// - reset_done never 1 while any reset output is 1.
// STRUCTURE
// - gt_rst_pkg:
//   - typedef enum logic [2:0] seq_state_t {RESET_PLL, WAIT_LOCK, WAIT_ACTIVE, DP_RESET, DONE, RETRY, FAILED}
//   - counter-width function
// - Sub-module bit_synchronizer (ASYNC_REG 2-flop, reset to 0), instantiated twice.
// - Top: FSM, counter, output registers.
// TESTING
// - Nominal:
//   - Stimulus: lock at cycle 100, active 20 cycles after bufg_clr falls.
//   - Expect: gt_pll_rst falls at cycle 17; bufg_clr falls at cycle 103; datapath_rst falls 32 cycles after active_s; reset_done=1 then.
// - Lock timeout:
//   - Stimulus: LOCK_TIMEOUT=64, lock never rises.
//   - Expect: retry_count 1, 2, 3; seq_error=1; resets held; start clears seq_error and restarts.
// - Active timeout then success:
//   - Stimulus: ACTIVE_TIMEOUT=32; active withheld for first attempt, given on second.
//   - Expect: retry_count=1; reset_done=1.
// - Loss in DONE:
//   - Stimulus: drop usrclk_active_async.
//   - Expect: 3 clk later datapath_rst=1, bufg_clr=1, reset_done=0, retry_count=0; full sequence repeats.
// - Async reset mid-DP_RESET:
//   - Stimulus: pulse rst_n low.
//   - Expect: all outputs at reset values immediately; sequence restarts from RESET_PLL.
// - Same-cycle events:
//   - Stimulus: start asserted in the same cycle as a timeout.
//   - Expect: RESET_PLL, retry_count=0.
//   - Stimulus: active_s rises on the ACTIVE_TIMEOUT-1 cycle.
//   - Expect: DP_RESET, no retry.

Source files
------------

// File: rtl/gt_rst_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gt_rst_pkg
// Brief    : Shared types and helpers for the GT reset sequencer.
// Revision : 1.0
// ============================================================================
package gt_rst_pkg;

    typedef enum logic [2:0] {
        RESET_PLL   = 3'd0,
        WAIT_LOCK   = 3'd1,
        WAIT_ACTIVE = 3'd2,
        DP_RESET    = 3'd3,
        DONE        = 3'd4,
        RETRY       = 3'd5,
        FAILED      = 3'd6
    } seq_state_t;

    typedef struct packed {
        logic pll_rst;
        logic clr;
        logic dp_rst;
        logic done;
    } rst_outs_t;

    localparam logic [3:0] c_retry_sat = 4'hF;

    // Counter must hold the largest terminal count of any timed state.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

    // RETRY holds every reset asserted: it always leads back into RESET_PLL or FAILED.
    function automatic rst_outs_t state_outs(input seq_state_t s);
        rst_outs_t o;
        case (s)
            WAIT_LOCK:   o = '{pll_rst: 1'b0, clr: 1'b1, dp_rst: 1'b1, done: 1'b0};
            WAIT_ACTIVE: o = '{pll_rst: 1'b0, clr: 1'b0, dp_rst: 1'b1, done: 1'b0};
            DP_RESET:    o = '{pll_rst: 1'b0, clr: 1'b0, dp_rst: 1'b1, done: 1'b0};
            DONE:        o = '{pll_rst: 1'b0, clr: 1'b0, dp_rst: 1'b0, done: 1'b1};
            default:     o = '{pll_rst: 1'b1, clr: 1'b1, dp_rst: 1'b1, done: 1'b0};
        endcase
        return o;
    endfunction

    function automatic logic [3:0] retry_inc(input logic [3:0] r);
        return (r == c_retry_sat) ? r : r + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gt_reset_sequencer_bit_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bit_synchronizer
// Brief    : Two-flop synchronizer for a single asynchronous level, resets to 0.
// Revision : 1.0
// ============================================================================
module bit_synchronizer (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    (* ASYNC_REG = "TRUE" *) logic r_meta;
    (* ASYNC_REG = "TRUE" *) logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/gt_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gt_reset_sequencer
// Brief    : Init-clock reset sequencer for GT PLL, BUFG_GT clear and datapath.
// Revision : 1.0
// ============================================================================
module gt_reset_sequencer
    import gt_rst_pkg::*;
#(
    parameter int CLR_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int ACTIVE_TIMEOUT = 1024,
    parameter int DP_RST_CYCLES  = 32,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pll_lock_async,
    input  logic       usrclk_active_async,
    output logic       gt_pll_rst,
    output logic       bufg_clr,
    output logic       datapath_rst,
    output logic       reset_done,
    output logic       seq_error,
    output logic [3:0] retry_count
);

    localparam int CW = cnt_width(CLR_CYCLES, LOCK_TIMEOUT, ACTIVE_TIMEOUT, DP_RST_CYCLES);

    localparam logic [CW-1:0] c_clr_last    = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] c_lock_last   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] c_active_last = CW'(ACTIVE_TIMEOUT - 1);
    localparam logic [CW-1:0] c_dp_last     = CW'(DP_RST_CYCLES - 1);
    localparam logic [3:0]    c_max_retries = 4'(MAX_RETRIES);

    logic          w_lock_s;
    logic          w_active_s;
    logic          w_link_ok;
    logic          w_restart;
    logic          w_counting;
    logic [3:0]    w_retry_inc;
    seq_state_t    w_next;
    logic [3:0]    w_retry_next;
    logic          w_err_next;

    seq_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_retry;
    logic          r_err;
    rst_outs_t     r_outs;

    bit_synchronizer u_sync_lock (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (pll_lock_async),
        .o_sync  (w_lock_s)
    );

    bit_synchronizer u_sync_active (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (usrclk_active_async),
        .o_sync  (w_active_s)
    );

    assign w_link_ok   = w_lock_s & w_active_s;
    assign w_retry_inc = retry_inc(r_retry);

    // Within each state, success checks precede timeout checks so a late
    // arrival on the terminal count still advances the sequence.
    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        w_err_next   = r_err;
        if (start) begin
            w_next       = RESET_PLL;
            w_retry_next = 4'd0;
            w_err_next   = 1'b0;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_cnt == c_clr_last) w_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (w_lock_s)                  w_next = WAIT_ACTIVE;
                    else if (r_cnt == c_lock_last) w_next = RETRY;
                end
                WAIT_ACTIVE: begin
                    if (!w_lock_s)                   w_next = RETRY;
                    else if (w_active_s)             w_next = DP_RESET;
                    else if (r_cnt == c_active_last) w_next = RETRY;
                end
                DP_RESET: begin
                    if (!w_link_ok) begin
                        w_next       = RESET_PLL;
                        w_retry_next = w_retry_inc;
                    end else if (r_cnt == c_dp_last) begin
                        w_next = DONE;
                    end
                end
                DONE: begin
                    if (!w_link_ok) begin
                        w_next       = RESET_PLL;
                        w_retry_next = 4'd0;
                    end
                end
                RETRY: begin
                    w_retry_next = w_retry_inc;
                    // >= also covers counts already raised by DP_RESET link drops.
                    if (w_retry_inc >= c_max_retries) begin
                        w_next     = FAILED;
                        w_err_next = 1'b1;
                    end else begin
                        w_next = RESET_PLL;
                    end
                end
                FAILED: begin
                    w_next = FAILED;
                end
                default: begin
                    w_next = RESET_PLL;
                end
            endcase
        end
    end

    assign w_restart  = start | (w_next != r_state);
    assign w_counting = (r_state == RESET_PLL) | (r_state == WAIT_LOCK) |
                        (r_state == WAIT_ACTIVE) | (r_state == DP_RESET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_PLL;
            r_cnt   <= '0;
            r_retry <= 4'd0;
            r_err   <= 1'b0;
            r_outs  <= state_outs(RESET_PLL);
        end else begin
            r_state <= w_next;
            r_retry <= w_retry_next;
            r_err   <= w_err_next;
            r_outs  <= state_outs(w_next);
            if (w_restart) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign gt_pll_rst   = r_outs.pll_rst;
    assign bufg_clr     = r_outs.clr;
    assign datapath_rst = r_outs.dp_rst;
    assign reset_done   = r_outs.done;
    assign seq_error    = r_err;
    assign retry_count  = r_retry;

endmodule
`default_nettype wire
